spi_txn_arbiter: RTL
====================

Name: spi_txn_arbiter

Overview:
- Shares one spi_module instance between NUM_REQ requesters. Sequences each SPI transfer: load config word, settle, pulse trans_en, wait for the interrupt, capture read data, return the response.
- Sits between on-chip masters (CPU port, DMA, test sequencer) and spi_module's i_data / i_data_config / i_trans_en / o_interrupt / o_data.
- Round-robin arbitration; exactly one transaction in flight.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_W, 8, SPI data width per transfer
- CFG_W, 32, config word width ({C1, C2, status, baud})
- SETTLE_CYC, 4, cycles config is held stable before trans_en (1..255)
- TIMEOUT_CYC, 4096, max cycles waiting for interrupt (SPI_ARB_TIMEOUT_EN only)

Ports:
- i_sys_clk  in  1  system clock
- i_sys_rst  in  1  synchronous, active-high reset
- i_req  in  NUM_REQ  per-requester request level
- i_req_data  in  NUM_REQ*DATA_W  tx data, slice k belongs to requester k
- i_req_cfg  in  NUM_REQ*CFG_W  config word, slice k
- o_grant  out  NUM_REQ  one-hot owner of current transaction, 0 when idle
- o_rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owner
- o_rsp_data  out  DATA_W  rx data, valid with o_rsp_valid
- o_busy  out  1  high whenever state != IDLE
- o_timeout  out  1  one-cycle pulse on timeout abort
- o_spi_data  out  DATA_W  to spi_module i_data
- o_spi_config  out  CFG_W  to spi_module i_data_config
- o_spi_trans_en  out  1  to spi_module i_trans_en
- i_spi_irq  in  1  from spi_module o_interrupt
- i_spi_data  in  DATA_W  from spi_module o_data

Behaviour:
- Reset (sync, active-high): state IDLE; o_grant, o_rsp_valid, o_rsp_data, o_busy, o_timeout, o_spi_data, o_spi_trans_en all 0; o_spi_config 0; rr pointer = 0; irq edge register = 0.
- Requester handshake: raise i_req with data/cfg stable; hold until own o_rsp_valid pulse. Dropping i_req while granted does not abort the transaction; the response pulse is still issued. i_req sampled only in IDLE.
- Arbitration (IDLE): first set i_req bit searching from rr pointer upward with wrap; latch winner's data and cfg into o_spi_data / o_spi_config; set o_grant; pointer := winner+1 mod NUM_REQ. No request: stay IDLE.
- FSM:
  - IDLE -> CFG when any request.
  - CFG: counter counts SETTLE_CYC cycles -> START.
  - START: o_spi_trans_en = 1 for exactly one cycle -> WAIT.
  - WAIT: on rising edge of i_spi_irq (irq & ~irq_q), capture i_spi_data -> DONE.
  - DONE: o_rsp_valid[owner] = 1 and o_rsp_data valid for one cycle; o_grant cleared the following cycle -> IDLE.
- Latency: grant to trans_en = SETTLE_CYC+1 cycles; irq edge to o_rsp_valid = 1 cycle; DONE to next grant >= 1 cycle (IDLE must be visited).
- Edge detect: an irq already high on entering WAIT (stale level) is ignored; a new rising edge is required. irq_q updates every cycle, in all states.
- o_spi_config and o_spi_data hold their last values in IDLE (spi_module never sees a config glitch between transactions).
- Simultaneous requests: rr order; a requester re-requesting immediately after DONE loses to any other pending requester.
- Reset mid-transaction: immediate return to IDLE; no o_rsp_valid issued; outputs reset.

Optional Feature:
- SPI_ARB_TIMEOUT_EN defined: WAIT counts cycles; after TIMEOUT_CYC cycles with no irq edge -> o_timeout pulses 1 cycle, o_rsp_valid[owner] pulses with o_rsp_data = all ones -> IDLE.
- Not defined: WAIT waits forever; o_timeout tied 0; no counter logic.

Test Plan:
- Single request: req0, data 8'hA5, cfg 32'hD610_8011, SETTLE_CYC=4 -> o_grant=01, o_spi_config=D6108011 from cycle after grant, trans_en pulse exactly 5 cycles after grant; irq rise with i_spi_data=8'h3C -> o_rsp_valid=01, o_rsp_data=3C next cycle.
- Contention: req0 and req1 both held high continuously -> grants alternate 01,10,01,10 across 4 transactions; each requester gets exactly 2 responses.
- Stale irq: i_spi_irq held high from before START -> no completion until irq falls and rises again; response 1 cycle after that rise.
- Reset in WAIT: assert i_sys_rst 1 cycle -> next cycle o_grant=0, o_busy=0, no rsp pulse; new req1 then served normally with rr pointer 0.
- Timeout (macro defined, TIMEOUT_CYC=16): no irq -> o_timeout and o_rsp_valid pulse 16 cycles after entering WAIT, o_rsp_data=8'hFF; with macro undefined, o_busy remains high.
- Request drop: req1 deasserted in WAIT -> o_rsp_valid=10 still pulses on irq edge, then IDLE.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_module between NUM_REQ requesters; one transfer in flight.
// Optional macro SPI_ARB_TIMEOUT_EN: abort WAIT after TIMEOUT_CYC cycles with an all-ones response.
module spi_txn_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 8,
  parameter int CFG_W       = 32,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ*CFG_W-1:0]  i_req_cfg,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_busy,
  output logic                      o_timeout,
  output logic [DATA_W-1:0]         o_spi_data,
  output logic [CFG_W-1:0]          o_spi_config,
  output logic                      o_spi_trans_en,
  input  logic                      i_spi_irq,
  input  logic [DATA_W-1:0]         i_spi_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
`else
  localparam int CNT_MAX = SETTLE_CYC;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_START, S_WAIT, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic               irq_q;
  logic               irq_rise;
  logic               found;
  logic [PTR_W-1:0]   win;
  int                 idx;

  assign irq_rise = i_spi_irq & ~irq_q;

  // First requester at or above the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

`ifndef SPI_ARB_TIMEOUT_EN
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      rr_ptr         <= '0;
      irq_q          <= 1'b0;
      o_grant        <= '0;
      o_rsp_valid    <= '0;
      o_rsp_data     <= '0;
      o_busy         <= 1'b0;
      o_spi_data     <= '0;
      o_spi_config   <= '0;
      o_spi_trans_en <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      o_timeout      <= 1'b0;
`endif
    end else begin
      irq_q          <= i_spi_irq;
      o_spi_trans_en <= 1'b0;
      o_rsp_valid    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      o_timeout      <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // spi data/config are only touched here so they stay stable between transfers
          if (found) begin
            o_grant      <= NUM_REQ'(1) << win;
            o_spi_data   <= i_req_data[win*DATA_W +: DATA_W];
            o_spi_config <= i_req_cfg[win*CFG_W +: CFG_W];
            rr_ptr       <= (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
            cnt          <= '0;
            o_busy       <= 1'b1;
            state        <= S_CFG;
          end
        end
        S_CFG: begin
          if (cnt == CNT_W'(SETTLE_CYC-1)) begin
            cnt   <= '0;
            state <= S_START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_START: begin
          o_spi_trans_en <= 1'b1;
          cnt            <= '0;
          state          <= S_WAIT;
        end
        S_WAIT: begin
          // a level already high on entry is stale; only a fresh edge completes
          if (irq_rise) begin
            o_rsp_valid <= o_grant;
            o_rsp_data  <= i_spi_data;
            state       <= S_DONE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYC-1)) begin
            o_timeout   <= 1'b1;
            o_rsp_valid <= o_grant;
            o_rsp_data  <= '1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
